kcpsmx_io_responder: RTL and testbench
======================================

KCPSMX_IO_RESPONDER -- requirements
Module: kcpsmx_io_responder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, RX/TX FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have parameter BASE_PORT, default 8'h00, port_id of register 0; registers occupy BASE_PORT..BASE_PORT+4.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port port_id  input  OPERAND_WIDTH  processor port address.
REQ-006 SHALL have port read_strobe  input  1  one-cycle processor read pulse.
REQ-007 SHALL have port write_strobe  input  1  one-cycle processor write pulse.
REQ-008 SHALL have port out_port  input  OPERAND_WIDTH  processor write data.
REQ-009 SHALL have port in_port  output  OPERAND_WIDTH  registered read data to processor.
REQ-010 SHALL have port interrupt  output  1  registered interrupt request.
REQ-011 SHALL have port interrupt_ack  input  1  processor interrupt acknowledge.
REQ-012 SHALL have ports rx_data/rx_valid/rx_ready  input/input/output  8/1/1  external byte stream into RX FIFO.
REQ-013 SHALL have ports tx_data/tx_valid/tx_ready  output/output/input  8/1/1  TX FIFO byte stream out.

Function
REQ-014 Register map (offset from BASE_PORT): 0 STATUS (R), 1 TX_DATA (W), 2 RX_DATA (R, pops), 3 IRQ_MASK (R/W, bits[3:0]), 4 IRQ_CLEAR (W1C).
REQ-015 STATUS = {rx_count[3:0], tx_full, rx_empty, irq_pending[1:0] of sticky bits 3:2}; unused high bits of rx_count zero.
REQ-016 in_port SHALL be updated every cycle with the mux of port_id (one-cycle latency); unmapped ports read 8'h00.
REQ-017 RX pop SHALL occur only on the read_strobe cycle with port_id = offset 2; pop of empty FIFO returns 8'h00, no pointer change.
REQ-018 Write with write_strobe at offset 1 pushes out_port into TX FIFO; write when full is dropped and sets sticky TX_OVF (bit 3).
REQ-019 rx_ready = RX not full; rx_valid&&rx_ready pushes rx_data; rx_valid while full sets sticky RX_OVF (bit 2).
REQ-020 tx_valid = TX not empty; tx_data = FIFO head; tx_valid&&tx_ready pops.
REQ-021 Simultaneous push and pop on the same FIFO SHALL both take effect (count unchanged), including at full (push accepted, no overflow) and empty (pop ignored, push accepted).
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-023 Sources: bit0 RX not empty (level), bit1 TX empty (level), bit2 RX_OVF, bit3 TX_OVF (sticky); IRQ_CLEAR write of 1 clears sticky bit; set and clear in same cycle -> set wins.
REQ-024 irq_req = |(sources & IRQ_MASK).
REQ-025 Interrupt FSM states IDLE, ASSERT, WAIT_CLR; interrupt = 1 only in ASSERT.
REQ-026 IDLE -> ASSERT when irq_req; ASSERT -> WAIT_CLR on interrupt_ack; WAIT_CLR -> IDLE when irq_req = 0.
REQ-027 interrupt_ack outside ASSERT SHALL be ignored.
REQ-028 Masking all sources while in ASSERT SHALL leave interrupt high until interrupt_ack.

Reset
REQ-029 On reset low: FIFOs empty, pointers 0, sticky bits 0, IRQ_MASK 0, FSM IDLE, in_port 8'h00, interrupt 0, tx_valid 0, rx_ready 1 after release.
REQ-030 Reset mid-transfer SHALL discard all FIFO contents without emitting any tx_valid beat.

Structure
REQ-031 Register offsets, irq bit indices and the FSM state enum SHALL live in package kcpsmx3_inc alongside OPERAND_WIDTH.
REQ-032 A single sub-module io_fifo (parameterised depth/width, push/pop/full/empty/count) SHALL be instantiated twice.

Verification
REQ-033 Push 3 bytes 8'hA1,8'hB2,8'hC3 on rx -> STATUS reads 8'h30 masked bits; three reads of offset 2 return A1,B2,C3; fourth returns 00.
REQ-034 Write 9 bytes to TX_DATA with tx_ready=0 (depth 8) -> tx_full=1, TX_OVF set; releasing tx_ready emits exactly 8 bytes in order.
REQ-035 IRQ_MASK=8'h01, push one rx byte -> interrupt rises next cycle, holds until interrupt_ack, stays low until RX drained, then IDLE.
REQ-036 RX full with rx_valid held and simultaneous pop -> byte accepted, no RX_OVF; without pop -> RX_OVF=1, cleared by IRQ_CLEAR write 8'h04.
REQ-037 Assert reset low while TX holds 4 bytes and interrupt=1 -> interrupt, tx_valid, in_port go 0 immediately; STATUS reads rx_empty=1 after release.

Source files
------------

// File: rtl/kcpsmx3_inc.sv
// Shared definitions for the KCPSM-style I/O responder.
// Holds the processor operand width, the register offsets relative to
// BASE_PORT, the interrupt source bit indices, the interrupt FSM state type
// and a helper that assembles the STATUS byte.
package kcpsmx3_inc;

  localparam int OPERAND_WIDTH = 8;

  // Register offsets from BASE_PORT
  localparam logic [OPERAND_WIDTH-1:0] OFF_STATUS    = 8'd0;
  localparam logic [OPERAND_WIDTH-1:0] OFF_TX_DATA   = 8'd1;
  localparam logic [OPERAND_WIDTH-1:0] OFF_RX_DATA   = 8'd2;
  localparam logic [OPERAND_WIDTH-1:0] OFF_IRQ_MASK  = 8'd3;
  localparam logic [OPERAND_WIDTH-1:0] OFF_IRQ_CLEAR = 8'd4;

  // Interrupt source bit indices
  localparam int IRQ_RX_NEMPTY = 0;  // level: RX FIFO holds data
  localparam int IRQ_TX_EMPTY  = 1;  // level: TX FIFO drained
  localparam int IRQ_RX_OVF    = 2;  // sticky: RX byte lost
  localparam int IRQ_TX_OVF    = 3;  // sticky: TX write dropped
  localparam int IRQ_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_WAIT_CLR = 2'd2
  } irq_state_t;

  // STATUS = {rx_count[3:0], tx_full, rx_empty, tx_ovf, rx_ovf}
  function automatic logic [OPERAND_WIDTH-1:0] pack_status(
    input logic [3:0] rx_cnt,
    input logic       tx_full,
    input logic       rx_empty,
    input logic       tx_ovf,
    input logic       rx_ovf
  );
    return {rx_cnt, tx_full, rx_empty, tx_ovf, rx_ovf};
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO used for both the RX and TX byte streams.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (pointers/count only)
//   i_push/i_wdata - push request and data
//   i_pop        - pop request (ignored while empty)
//   o_rdata      - head of FIFO (valid when !o_empty)
//   o_full/o_empty/o_count - occupancy
// A push while full is accepted only when a pop happens in the same cycle.
module io_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push_acc;
  logic              w_pop_acc;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_rdata    = r_mem[r_rd_ptr];

  assign w_pop_acc  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_acc = i_push && (!o_full || w_pop_acc);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push_acc) - CW'(w_pop_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/kcpsmx_io_responder.sv
// Memory-mapped I/O responder for a KCPSM-style soft processor.
// Five registers at BASE_PORT..BASE_PORT+4: STATUS, TX_DATA, RX_DATA (pop on
// read strobe), IRQ_MASK, IRQ_CLEAR (write 1 to clear sticky overflow bits).
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   port_id, read_strobe, write_strobe, out_port - processor I/O bus
//   in_port           - registered read data, follows port_id each cycle
//   interrupt, interrupt_ack - interrupt request / acknowledge handshake
//   rx_data/rx_valid/rx_ready - inbound byte stream into the RX FIFO
//   tx_data/tx_valid/tx_ready - outbound byte stream from the TX FIFO
module kcpsmx_io_responder
  import kcpsmx3_inc::*;
#(
  parameter int                       FIFO_DEPTH = 8,
  parameter logic [OPERAND_WIDTH-1:0] BASE_PORT  = 8'h00
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [OPERAND_WIDTH-1:0] port_id,
  input  logic                     read_strobe,
  input  logic                     write_strobe,
  input  logic [OPERAND_WIDTH-1:0] out_port,
  output logic [OPERAND_WIDTH-1:0] in_port,
  output logic                     interrupt,
  input  logic                     interrupt_ack,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [OPERAND_WIDTH-1:0] w_offset;
  logic                     w_sel_tx, w_sel_rx, w_sel_mask, w_sel_clr;

  logic [7:0]    w_rx_head;
  logic          w_rx_full, w_rx_empty;
  logic [CW-1:0] w_rx_count;
  logic [3:0]    w_rx_cnt4;
  logic          w_rx_pop_req, w_rx_pop_acc;

  logic          w_tx_full, w_tx_empty;
  logic [CW-1:0] w_tx_count;
  logic          w_tx_push_req, w_tx_pop_acc;

  logic          r_rx_ovf, r_tx_ovf;
  logic          w_rx_ovf_set, w_tx_ovf_set;
  logic          w_rx_ovf_clr, w_tx_ovf_clr;
  logic [IRQ_W-1:0] r_irq_mask;
  logic [IRQ_W-1:0] w_irq_src;
  logic          w_irq_req;

  irq_state_t    r_state, w_state_nxt;
  logic          w_interrupt;

  logic [OPERAND_WIDTH-1:0] w_rd_data;
  logic [OPERAND_WIDTH-1:0] r_in_port;

  // ---------------- address decode ----------------
  assign w_offset   = port_id - BASE_PORT;
  assign w_sel_tx   = (w_offset == OFF_TX_DATA);
  assign w_sel_rx   = (w_offset == OFF_RX_DATA);
  assign w_sel_mask = (w_offset == OFF_IRQ_MASK);
  assign w_sel_clr  = (w_offset == OFF_IRQ_CLEAR);

  // ---------------- RX path ----------------
  // rx_valid is offered to the FIFO even when full: a same-cycle pop makes
  // room, so the byte is taken and no overflow is flagged.
  assign w_rx_pop_req = read_strobe && w_sel_rx;
  assign w_rx_pop_acc = w_rx_pop_req && !w_rx_empty;
  assign w_rx_ovf_set = rx_valid && w_rx_full && !w_rx_pop_acc;
  assign rx_ready     = !w_rx_full;

  io_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (rx_valid),
    .i_wdata (rx_data),
    .i_pop   (w_rx_pop_req),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  if (CW >= 4) begin : g_cnt_trunc
    assign w_rx_cnt4 = w_rx_count[3:0];
  end else begin : g_cnt_ext
    assign w_rx_cnt4 = 4'(w_rx_count);
  end

  // ---------------- TX path ----------------
  assign w_tx_push_req = write_strobe && w_sel_tx;
  assign w_tx_pop_acc  = tx_ready && !w_tx_empty;
  assign w_tx_ovf_set  = w_tx_push_req && w_tx_full && !w_tx_pop_acc;
  assign tx_valid      = !w_tx_empty;

  io_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_tx_push_req),
    .i_wdata (out_port),
    .i_pop   (tx_ready),
    .o_rdata (tx_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  // ---------------- interrupt sources ----------------
  assign w_rx_ovf_clr = write_strobe && w_sel_clr && out_port[IRQ_RX_OVF];
  assign w_tx_ovf_clr = write_strobe && w_sel_clr && out_port[IRQ_TX_OVF];

  // Set is ORed after the clear so a coincident event is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_ovf   <= 1'b0;
      r_tx_ovf   <= 1'b0;
      r_irq_mask <= '0;
    end else begin
      r_rx_ovf <= w_rx_ovf_set || (r_rx_ovf && !w_rx_ovf_clr);
      r_tx_ovf <= w_tx_ovf_set || (r_tx_ovf && !w_tx_ovf_clr);
      if (write_strobe && w_sel_mask) r_irq_mask <= out_port[IRQ_W-1:0];
    end
  end

  always_comb begin
    w_irq_src                = '0;
    w_irq_src[IRQ_RX_NEMPTY] = !w_rx_empty;
    w_irq_src[IRQ_TX_EMPTY]  = (w_tx_count == '0);
    w_irq_src[IRQ_RX_OVF]    = r_rx_ovf;
    w_irq_src[IRQ_TX_OVF]    = r_tx_ovf;
  end

  assign w_irq_req = |(w_irq_src & r_irq_mask);

  // ---------------- interrupt FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Once asserted, the request is held until acknowledged regardless of the
  // mask; after the ack we wait for the cause to go away before re-arming.
  always_comb begin
    w_state_nxt = r_state;
    w_interrupt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_irq_req) w_state_nxt = ST_ASSERT;
      end
      ST_ASSERT: begin
        w_interrupt = 1'b1;
        if (interrupt_ack) w_state_nxt = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        if (!w_irq_req) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign interrupt = w_interrupt;

  // ---------------- read mux ----------------
  always_comb begin
    w_rd_data = '0;
    case (w_offset)
      OFF_STATUS:   w_rd_data = pack_status(w_rx_cnt4, w_tx_full, w_rx_empty,
                                            r_tx_ovf, r_rx_ovf);
      OFF_RX_DATA:  w_rd_data = w_rx_empty ? '0 : w_rx_head;
      OFF_IRQ_MASK: w_rd_data = {{(OPERAND_WIDTH-IRQ_W){1'b0}}, r_irq_mask};
      default:      w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_in_port <= '0;
    else        r_in_port <= w_rd_data;
  end

  assign in_port = r_in_port;

endmodule

// File: tb/tb_kcpsmx_io_responder.sv
module tb_kcpsmx_io_responder;

  localparam int         D    = 8;
  localparam logic [7:0] BASE = 8'h40;

  logic       clk;
  logic       reset;
  logic [7:0] port_id;
  logic       read_strobe;
  logic       write_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int n_vec;
  int n_err;

  // Reference model state
  logic [7:0] m_rx_q[$];
  logic [7:0] m_tx_q[$];
  logic       m_rx_ovf, m_tx_ovf;
  logic [3:0] m_mask;
  logic       m_int;    // interrupt line high
  logic       m_wait;   // acknowledged, waiting for cause to disappear
  logic [7:0] m_in;

  kcpsmx_io_responder #(
    .FIFO_DEPTH (D),
    .BASE_PORT  (BASE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .port_id       (port_id),
    .read_strobe   (read_strobe),
    .write_strobe  (write_strobe),
    .out_port      (out_port),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic m_reset();
    m_rx_q.delete();
    m_tx_q.delete();
    m_rx_ovf = 1'b0;
    m_tx_ovf = 1'b0;
    m_mask   = 4'h0;
    m_int    = 1'b0;
    m_wait   = 1'b0;
    m_in     = 8'h00;
  endtask

  // Applies one clock edge of behaviour to the model, using the inputs that
  // were stable before the edge and the model state before the edge.
  task automatic model_update();
    logic [7:0] off;
    logic [7:0] nxt_in;
    logic [3:0] src;
    logic [1:0] clr;
    logic       req, rx_pop, rx_push, tx_pop, tx_wr, tx_push, n_rx_ovf, n_tx_ovf;
    off = port_id - BASE;
    src = {m_tx_ovf, m_rx_ovf, (m_tx_q.size() == 0), (m_rx_q.size() != 0)};
    req = |(src & m_mask);
    case (off)
      8'd0:    nxt_in = {4'(m_rx_q.size()), (m_tx_q.size() == D),
                         (m_rx_q.size() == 0), m_tx_ovf, m_rx_ovf};
      8'd2:    nxt_in = (m_rx_q.size() != 0) ? m_rx_q[0] : 8'h00;
      8'd3:    nxt_in = {4'h0, m_mask};
      default: nxt_in = 8'h00;
    endcase
    rx_pop  = read_strobe && (off == 8'd2) && (m_rx_q.size() != 0);
    rx_push = rx_valid && ((m_rx_q.size() < D) || rx_pop);
    tx_pop  = tx_ready && (m_tx_q.size() != 0);
    tx_wr   = write_strobe && (off == 8'd1);
    tx_push = tx_wr && ((m_tx_q.size() < D) || tx_pop);
    clr     = (write_strobe && off == 8'd4) ? out_port[3:2] : 2'b00;
    n_rx_ovf = (rx_valid && !rx_push) || (m_rx_ovf && !clr[0]);
    n_tx_ovf = (tx_wr && !tx_push) || (m_tx_ovf && !clr[1]);
    if (m_int) begin
      if (interrupt_ack) begin
        m_int  = 1'b0;
        m_wait = 1'b1;
      end
    end else if (m_wait) begin
      if (!req) m_wait = 1'b0;
    end else if (req) begin
      m_int = 1'b1;
    end
    if (write_strobe && off == 8'd3) m_mask = out_port[3:0];
    if (rx_pop)  void'(m_rx_q.pop_front());
    if (rx_push) m_rx_q.push_back(rx_data);
    if (tx_pop)  void'(m_tx_q.pop_front());
    if (tx_push) m_tx_q.push_back(out_port);
    m_rx_ovf = n_rx_ovf;
    m_tx_ovf = n_tx_ovf;
    m_in     = nxt_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    port_id       = BASE;
    read_strobe   = 1'b0;
    write_strobe  = 1'b0;
    out_port      = 8'h00;
    interrupt_ack = 1'b0;
    rx_data       = 8'h00;
    rx_valid      = 1'b0;
    tx_ready      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    m_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] val);
    port_id      = BASE + off;
    out_port     = val;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    m_reset();
    #3;
    n_vec++; if (in_port !== 8'h00) begin n_err++; $display("FAIL reset_in_port: got %h want 00", in_port); end
    n_vec++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", interrupt); end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    @(negedge clk);
    reset = 1'b1;
    n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    port_id = BASE;
    tick();
    n_vec++; if (in_port !== 8'h04) begin n_err++; $display("FAIL reset_status: got %h want 04", in_port); end
    port_id = BASE + 8'd3;
    tick();
    n_vec++; if (in_port !== 8'h00) begin n_err++; $display("FAIL reset_mask: got %h want 00", in_port); end
  endtask

  task automatic test_rx_basic();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'h00;
    do_reset();
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = exp_b[i];
      tick();
    end
    rx_valid = 1'b0;
    port_id  = BASE;
    tick();
    n_vec++; if (in_port !== 8'h30) begin n_err++; $display("FAIL rx3_status: got %h want 30", in_port); end
    port_id     = BASE + 8'd2;
    read_strobe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (in_port !== exp_b[i]) begin n_err++; $display("FAIL rx_pop%0d: got %h want %h", i, in_port, exp_b[i]); end
    end
    read_strobe = 1'b0;
    port_id     = BASE;
    tick();
    n_vec++; if (in_port !== 8'h04) begin n_err++; $display("FAIL rx_drained_status: got %h want 04", in_port); end
    port_id = BASE + 8'd5;
    tick();
    n_vec++; if (in_port !== 8'h00) begin n_err++; $display("FAIL unmapped_hi: got %h want 00", in_port); end
    port_id = BASE - 8'd1;
    tick();
    n_vec++; if (in_port !== 8'h00) begin n_err++; $display("FAIL unmapped_lo: got %h want 00", in_port); end
  endtask

  task automatic test_tx_overflow();
    int got;
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(8'd1, 8'h10 + 8'(i));
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin n_err++; $display("FAIL tx_head: got v=%b d=%h want v=1 d=10", tx_valid, tx_data); end
    port_id = BASE;
    tick();
    n_vec++; if (in_port !== 8'h0E) begin n_err++; $display("FAIL tx_full_status: got %h want 0e", in_port); end
    tx_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && tx_valid === 1'b1; c++) begin
      n_vec++; if (tx_data !== 8'h10 + 8'(got)) begin n_err++; $display("FAIL tx_order%0d: got %h want %h", got, tx_data, 8'h10 + 8'(got)); end
      got++;
      tick();
    end
    n_vec++; if (got != 8) begin n_err++; $display("FAIL tx_beats: got %0d want 8", got); end
    tick();
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_idle: got %b want 0", tx_valid); end
    wr(8'd4, 8'h08);
    port_id = BASE;
    tick();
    n_vec++; if (in_port !== 8'h04) begin n_err++; $display("FAIL tx_ovf_clear: got %h want 04", in_port); end
  endtask

  task automatic test_irq();
    do_reset();
    wr(8'd3, 8'h01);
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    n_vec++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b want 0", interrupt); end
    interrupt_ack = 1'b1;   // not in ASSERT yet, must be ignored
    tick();
    interrupt_ack = 1'b0;
    n_vec++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL irq_rise: got %b want 1", interrupt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL irq_hold%0d: got %b want 1", i, interrupt); end
    end
    wr(8'd3, 8'h00);
    tick();
    n_vec++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL irq_masked_hold: got %b want 1", interrupt); end
    wr(8'd3, 8'h01);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    n_vec++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL irq_ack_drop: got %b want 0", interrupt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL irq_wait_low%0d: got %b want 0", i, interrupt); end
    end
    port_id     = BASE + 8'd2;
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    n_vec++; if (in_port !== 8'h5A) begin n_err++; $display("FAIL irq_drain: got %h want 5a", in_port); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL irq_idle_low%0d: got %b want 0", i, interrupt); end
    end
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    n_vec++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL irq_rearm: got %b want 1", interrupt); end
    n_vec++; if (interrupt !== m_int) begin n_err++; $display("FAIL irq_model: got %b want %b", interrupt, m_int); end
  endtask

  task automatic test_rx_full_pop();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    do_reset();
    rx_valid = 1'b1;
    for (int i = 0; i < D; i++) begin
      b = 8'($urandom);
      rx_data = b;
      exp_q.push_back(b);
      tick();
    end
    n_vec++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL rx_full_ready: got %b want 0", rx_ready); end
    rx_data     = 8'h77;
    port_id     = BASE + 8'd2;
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    rx_valid    = 1'b0;
    n_vec++; if (in_port !== exp_q[0]) begin n_err++; $display("FAIL rx_full_pop: got %h want %h", in_port, exp_q[0]); end
    void'(exp_q.pop_front());
    exp_q.push_back(8'h77);
    port_id = BASE;
    tick();
    n_vec++; if (in_port !== 8'h80) begin n_err++; $display("FAIL rx_full_no_ovf: got %h want 80", in_port); end
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    n_vec++; if (in_port !== 8'h81) begin n_err++; $display("FAIL rx_ovf_set: got %h want 81", in_port); end
    rx_valid = 1'b1;        // new overflow coincides with the clear: set wins
    wr(8'd4, 8'h04);
    rx_valid = 1'b0;
    port_id  = BASE;
    tick();
    n_vec++; if (in_port !== 8'h81) begin n_err++; $display("FAIL rx_ovf_set_wins: got %h want 81", in_port); end
    wr(8'd4, 8'h04);
    port_id = BASE;
    tick();
    n_vec++; if (in_port !== 8'h80) begin n_err++; $display("FAIL rx_ovf_clear: got %h want 80", in_port); end
    port_id     = BASE + 8'd2;
    read_strobe = 1'b1;
    for (int i = 0; i < D; i++) begin
      tick();
      n_vec++; if (in_port !== exp_q[i]) begin n_err++; $display("FAIL rx_full_order%0d: got %h want %h", i, in_port, exp_q[i]); end
    end
    read_strobe = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      port_id       = BASE + 8'($urandom_range(0, 6));
      read_strobe   = ($urandom_range(0, 2) == 0);
      write_strobe  = ($urandom_range(0, 2) == 0);
      out_port      = 8'($urandom);
      rx_data       = 8'($urandom);
      rx_valid      = ($urandom_range(0, 1) == 1);
      tx_ready      = (c < 300) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
      interrupt_ack = ($urandom_range(0, 7) == 0);
      tick();
      n_vec++; if (in_port !== m_in) begin n_err++; $display("FAIL rnd_in_port c%0d: got %h want %h", c, in_port, m_in); end
      n_vec++; if (interrupt !== m_int) begin n_err++; $display("FAIL rnd_irq c%0d: got %b want %b", c, interrupt, m_int); end
      n_vec++; if (tx_valid !== (m_tx_q.size() != 0)) begin n_err++; $display("FAIL rnd_tx_valid c%0d: got %b want %b", c, tx_valid, (m_tx_q.size() != 0)); end
      if (m_tx_q.size() != 0) begin
        n_vec++; if (tx_data !== m_tx_q[0]) begin n_err++; $display("FAIL rnd_tx_data c%0d: got %h want %h", c, tx_data, m_tx_q[0]); end
      end
      n_vec++; if (rx_ready !== (m_rx_q.size() < D)) begin n_err++; $display("FAIL rnd_rx_ready c%0d: got %b want %b", c, rx_ready, (m_rx_q.size() < D)); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int waited;
    do_reset();
    wr(8'd3, 8'h01);
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'd1, 8'hE0 + 8'(i));
    rx_valid = 1'b1;
    rx_data  = 8'h3C;
    port_id  = BASE;
    tick();
    rx_valid = 1'b0;
    waited = 0;
    while (interrupt !== 1'b1 && waited < 5) begin
      tick();
      waited++;
    end
    n_vec++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL rmid_irq_up: got %b want 1", interrupt); end
    n_vec++; if (in_port !== 8'h10) begin n_err++; $display("FAIL rmid_status: got %h want 10", in_port); end
    #2;
    reset = 1'b0;
    m_reset();
    #1;
    n_vec++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL rmid_irq: got %b want 0", interrupt); end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rmid_tx_valid: got %b want 0", tx_valid); end
    n_vec++; if (in_port !== 8'h00) begin n_err++; $display("FAIL rmid_in_port: got %h want 00", in_port); end
    @(negedge clk);
    reset    = 1'b1;
    tx_ready = 1'b1;
    port_id  = BASE;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_beat%0d: got %b want 0", i, tx_valid); end
    end
    n_vec++; if (in_port !== 8'h04) begin n_err++; $display("FAIL rmid_status_after: got %h want 04", in_port); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_rx_basic();
    test_tx_overflow();
    test_irq();
    test_rx_full_pop();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
